fast_sampler_packer: RTL and testbench
======================================

// Module: fast_sampler_packer
// PURPOSE
//   Parametrised fast-clock-domain acquisition front end for the logic analyser. It synchronises
//   NUM_CH probe inputs and samples them on a programmable divided tick. Each enabled channel
//   packs WORD_W consecutive samples into a word. Completed words leave on a single ready/valid
//   stream, tagged with their channel index. The downstream FIFO/clock-crossing logic applies
//   backpressure on that stream; if a channel's word would be lost, a sticky overflow flag is set.
// PARAMETERS
//   NUM_CH  16  number of probe channels (1..32)
//   WORD_W  16  samples packed per output word (2..32)
//   DIV_W   8   width of clock_divisor
//   CH_W        localparam = max(1,$clog2(NUM_CH)), width of out_channel
// PORTS
//   clk             in   1       fast sample clock
//   rst_n           in   1       asynchronous, active-low reset
//   probe           in   NUM_CH  raw asynchronous probe inputs
//   acq_enable      in   1       acquisition run; low = idle/flush
//   clock_divisor   in   DIV_W   tick period = clock_divisor+1 clk cycles
//   channel_enable  in   NUM_CH  per-channel enable, latched at acquisition start
//   out_data        out  WORD_W  packed word; bit k = k-th sample of that word
//   out_channel     out  CH_W    channel index of out_data
//   out_valid       out  1       word presented
//   out_ready       in   1       consumer accepts when out_valid & out_ready
//   overflow        out  1       sticky: a completed word was dropped
// BEHAVIOUR
// - Reset (rst_n low, async): all state 0. out_valid=0, out_data=0, out_channel=0, overflow=0.
// - Sync: a 2-flop synchroniser per probe bit, reset to 0. Always runs, independent of acq_enable.
// - acq_enable low: divider, shift registers, bit counters, pending bits and the output stage
//   are cleared synchronously. out_valid=0 on the next cycle. overflow is cleared.
// - Start: on the first cycle with acq_enable high, channel_enable is copied into ch_en_q.
//   Changes to channel_enable during the run are ignored.
// - Divider: a down-counter starts at 0 on the first enabled cycle. When it is 0, tick=1 and
//   the counter reloads from clock_divisor; otherwise it decrements. The first tick therefore
//   falls on the first acq_enable-high cycle. clock_divisor=0 gives a tick on every cycle.
//   clock_divisor is sampled at each reload.
// - Packing: on a tick, each channel with ch_en_q set shifts its synced bit in at the MSB and
//   shifts right, so the oldest sample ends up in bit 0. Its bit counter (0..WORD_W-1) then
//   increments.
// - Word completion: on the tick where the bit counter equals WORD_W-1, three things happen
//   at the end of that same cycle (cycle T):
//     - the full word, including the current bit, is written to the channel's hold register;
//     - pending is set;
//     - the bit counter wraps to 0.
//   All enabled channels complete on the same tick.
// - Overflow: if a word completes while that channel's pending is still 1 and the bit is not
//   being cleared in the same cycle, the new word is dropped, the old hold word is kept and
//   overflow is set. overflow stays set until acq_enable goes low.
// - Output stage: one register. It loads when empty or when a transfer (valid&ready) occurs in
//   that cycle. It takes the lowest-index channel with pending=1 and clears that channel's
//   pending in the same cycle.
//     - Latency: tick in cycle T -> out_valid high in cycle T+2 (with out_ready held high).
//     - Sustained rate: one word per cycle while out_ready=1.
//     - Words from one tick group come out in ascending channel order.
// - Stream hold: while out_valid=1 and out_ready=0, out_data and out_channel stay stable.
//   out_valid never drops without a transfer, except on an acq_enable-low flush.
// - Disabled channels never set pending and never appear on the stream.
// - ch_en_q == 0 while running: ticks still occur, but no output is produced.
// - Reset asserted mid-run: everything clears immediately. The run resumes only after rst_n
//   rises, and restarts from the first-cycle behaviour.
// TESTING
// 1. NUM_CH=4, WORD_W=8, div=0, en=4'b0001, probe[0] pattern 1,0,1,1,0,0,1,0 after sync
//    -> out_data=8'h4D, out_channel=0, first out_valid 2 cycles after the 8th tick.
// 2. div=3, en=4'b1111, probes held at 4'b1010, out_ready=1
//    -> ticks every 4 cycles; per group, channels 0,1,2,3 on 4 consecutive cycles with
//    data 00,FF,00,FF; overflow stays 0.
// 3. div=0, en=4'b1111, WORD_W=2, out_ready=1
//    -> completion every 2 cycles with 4 words pending; overflow=1; accepted words are
//    contiguous per channel.
// 4. Backpressure: out_ready=0 for 20 cycles while out_valid=1
//    -> out_data/out_channel stable; on out_ready=1 the transfer completes and the next
//    channel follows next cycle.
// 5. channel_enable changed 4'b0001->4'b0010 mid-run -> only channel 0 is output until
//    acq_enable toggles low/high; acq_enable low for 1 cycle -> out_valid=0, overflow=0.
// 6. rst_n asserted asynchronously mid-word -> outputs 0 immediately (before the next clk
//    edge); after release, the first word is a full WORD_W fresh samples.

Source files
------------

// File: rtl/fast_sampler_packer.sv
// Acquisition front end: synchronises probes, samples them on a divided tick and packs WORD_W samples per channel word.
// Latency: a tick in cycle T presents the word in cycle T+2; the probe-to-sample path adds 2 synchroniser cycles.
// Backpressure: the word is held stable until out_ready; a word completing over an unsent one is dropped and sets overflow.
module fast_sampler_packer #(
    parameter int NUM_CH = 16,
    parameter int WORD_W = 16,
    parameter int DIV_W  = 8,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] probe,
    input  logic              acq_enable,
    input  logic [DIV_W-1:0]  clock_divisor,
    input  logic [NUM_CH-1:0] channel_enable,
    output logic [WORD_W-1:0] out_data,
    output logic [CH_W-1:0]   out_channel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow
);

    localparam int CNT_W = $clog2(WORD_W);

    logic [NUM_CH-1:0] sync1_q, sync2_q;
    logic              run_q;
    logic [NUM_CH-1:0] ch_en_q;
    logic [NUM_CH-1:0] en_use;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              tick;

    logic [WORD_W-1:0] shift_q [NUM_CH];
    logic [WORD_W-1:0] shift_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [WORD_W-1:0] hold_q  [NUM_CH];
    logic [WORD_W-1:0] hold_d  [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d, clr;
    logic              ovf_q, ovf_d;

    logic              load;
    logic              pick_vld;
    logic [CH_W-1:0]   pick_idx;
    logic              out_vld_q, out_vld_d;
    logic [WORD_W-1:0] out_dat_q, out_dat_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;

    // Enables are taken live on the first run cycle (not yet latched), from the latch afterwards.
    always_comb begin
        en_use = run_q ? ch_en_q : channel_enable;
        tick   = acq_enable && (div_q == '0);
        div_d  = (div_q == '0) ? clock_divisor : div_q - 1'b1;
    end

    // Lowest-index pending channel wins the output register.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                pick_vld = 1'b1;
                pick_idx = CH_W'(i);
            end
        end
    end

    // Output register refills when empty or when its word is being taken this cycle.
    always_comb begin
        load      = !out_vld_q || out_ready;
        clr       = '0;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        out_ch_d  = out_ch_q;
        if (load) begin
            out_vld_d = pick_vld;
            if (pick_vld) begin
                clr[pick_idx] = 1'b1;
                out_dat_d     = hold_q[pick_idx];
                out_ch_d      = pick_idx;
            end
        end
    end

    // Per-channel shift/count on a tick; a completed word goes to hold unless hold is still occupied.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        pend_d  = pend_q & ~clr;
        ovf_d   = ovf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tick && en_use[i]) begin
                shift_d[i] = {sync2_q[i], shift_q[i][WORD_W-1:1]};
                if (cnt_q[i] == CNT_W'(WORD_W - 1)) begin
                    cnt_d[i] = '0;
                    if (pend_q[i] && !clr[i]) begin
                        ovf_d = 1'b1;
                    end else begin
                        hold_d[i] = shift_d[i];
                        pend_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Probe synchronisers run regardless of acquisition state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= probe;
            sync2_q <= sync1_q;
        end
    end

    // Acquisition state: flushed while acq_enable is low, advanced from the next-state terms otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            ch_en_q   <= '0;
            div_q     <= '0;
            shift_q   <= '{default: '0};
            cnt_q     <= '{default: '0};
            hold_q    <= '{default: '0};
            pend_q    <= '0;
            ovf_q     <= 1'b0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_ch_q  <= '0;
        end else if (!acq_enable) begin
            run_q     <= 1'b0;
            div_q     <= '0;
            shift_q   <= '{default: '0};
            cnt_q     <= '{default: '0};
            pend_q    <= '0;
            ovf_q     <= 1'b0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_ch_q  <= '0;
        end else begin
            run_q <= 1'b1;
            if (!run_q) begin
                ch_en_q <= channel_enable;
            end
            div_q     <= div_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            out_ch_q  <= out_ch_d;
        end
    end

    assign out_valid   = out_vld_q;
    assign out_data    = out_dat_q;
    assign out_channel = out_ch_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_fast_sampler_packer.sv
// Bench for fast_sampler_packer (4 channels, 8-sample words) against a behavioural model.
// Inputs change just after the falling edge; outputs are compared on the falling edge.
// Directed scenarios first, then a randomized run with random backpressure and flushes.
module tb_fast_sampler_packer;

    localparam int NCH = 4;
    localparam int WW  = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] probe;
    logic       acq_enable;
    logic [7:0] clock_divisor;
    logic [3:0] channel_enable;
    logic [7:0] out_data;
    logic [1:0] out_channel;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;

    int n_checks = 0;
    int n_err    = 0;

    fast_sampler_packer #(.NUM_CH(NCH), .WORD_W(WW), .DIV_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .probe          (probe),
        .acq_enable     (acq_enable),
        .clock_divisor  (clock_divisor),
        .channel_enable (channel_enable),
        .out_data       (out_data),
        .out_channel    (out_channel),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: samples gathered arithmetically, one held word per channel.
    logic [3:0] m_hist[$];
    bit         m_running;
    logic [3:0] m_en;
    int         m_wait;
    int         m_nsamp[NCH];
    int         m_acc[NCH];
    int         m_hold[NCH];
    bit         m_pend[NCH];
    bit         m_ov;
    int         m_od;
    int         m_oc;
    bit         m_ovf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_flush();
        m_running = 1'b0;
        m_wait    = 0;
        for (int i = 0; i < NCH; i++) begin
            m_nsamp[i] = 0;
            m_acc[i]   = 0;
            m_pend[i]  = 1'b0;
        end
        m_ov  = 1'b0;
        m_od  = 0;
        m_oc  = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_reset();
        model_flush();
        m_hist.delete();
        m_hist.push_back(4'b0);
        m_hist.push_back(4'b0);
        m_en = 4'b0;
        for (int i = 0; i < NCH; i++) m_hold[i] = 0;
    endtask

    task automatic model_step(input logic [3:0] p, input logic acq, input logic [7:0] dv,
                              input logic [3:0] en, input logic rdy);
        logic [3:0] synced;
        bit         tick;
        int         pick;
        synced = m_hist[0];
        void'(m_hist.pop_front());
        m_hist.push_back(p);
        if (!acq) begin
            model_flush();
            return;
        end
        if (!m_running) begin
            m_en      = en;
            m_running = 1'b1;
        end
        tick   = (m_wait == 0);
        m_wait = tick ? int'(dv) : m_wait - 1;
        // Output register first: it sees the pending state from before this cycle's completions.
        if (!m_ov || rdy) begin
            pick = -1;
            for (int i = NCH - 1; i >= 0; i--) if (m_pend[i]) pick = i;
            if (pick >= 0) begin
                m_ov         = 1'b1;
                m_od         = m_hold[pick];
                m_oc         = pick;
                m_pend[pick] = 1'b0;
            end else begin
                m_ov = 1'b0;
            end
        end
        if (tick) begin
            for (int i = 0; i < NCH; i++) begin
                if (m_en[i]) begin
                    m_acc[i]   = m_acc[i] + int'(synced[i]) * (1 << m_nsamp[i]);
                    m_nsamp[i] = m_nsamp[i] + 1;
                    if (m_nsamp[i] == WW) begin
                        if (m_pend[i]) begin
                            m_ovf = 1'b1;
                        end else begin
                            m_hold[i] = m_acc[i];
                            m_pend[i] = 1'b1;
                        end
                        m_acc[i]   = 0;
                        m_nsamp[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        check_val("out_valid",   32'(out_valid),   32'(m_ov));
        check_val("out_data",    32'(out_data),    m_od);
        check_val("out_channel", 32'(out_channel), m_oc);
        check_val("overflow",    32'(overflow),    32'(m_ovf));
    endtask

    task automatic run_cycle(input logic [3:0] p, input logic acq, input logic [7:0] dv,
                             input logic [3:0] en, input logic rdy);
        check_outputs();
        probe          = p;
        acq_enable     = acq;
        clock_divisor  = dv;
        channel_enable = en;
        out_ready      = rdy;
        model_step(p, acq, dv, en, rdy);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] pat;
        logic [3:0] p;

        rst_n = 1'b0;
        probe = '0; acq_enable = 1'b0; clock_divisor = '0; channel_enable = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Channel 0 alone, tick every cycle, synced samples 1,0,1,1,0,0,1,0.
        pat = 8'h4D;
        for (int c = 0; c < 10; c++) begin
            p    = 4'($urandom) & 4'b1110;
            p[0] = (c < 8) ? pat[c] : 1'b0;
            run_cycle(p, c >= 2, 8'd0, 4'b0001, 1'b1);
        end
        check_val("t1_not_early", 32'(out_valid), 32'd0);
        run_cycle(4'b0, 1'b1, 8'd0, 4'b0001, 1'b1);
        check_val("t1_valid", 32'(out_valid),   32'd1);
        check_val("t1_data",  32'(out_data),    32'h4D);
        check_val("t1_chan",  32'(out_channel), 32'd0);

        // Static 1010 probes, tick every 4 cycles, all channels, no backpressure.
        repeat (3) run_cycle(4'b1010, 1'b0, 8'd3, 4'b1111, 1'b1);
        for (int c = 0; c < 80; c++) begin
            run_cycle(4'b1010, 1'b1, 8'd3, 4'b1111, 1'b1);
            if (out_valid) check_val("t2_word", 32'(out_data), out_channel[0] ? 32'hFF : 32'h00);
        end
        check_val("t2_no_ovf", 32'(overflow), 32'd0);

        // Tick every cycle with the consumer stalled: words pile up and get dropped.
        run_cycle(4'b0, 1'b0, 8'd0, 4'b1111, 1'b0);
        for (int c = 0; c < 20; c++) run_cycle(4'($urandom), 1'b1, 8'd0, 4'b1111, 1'b0);
        check_val("t3_ovf", 32'(overflow), 32'd1);
        // Long stall then release; the model tracks hold stability and channel order.
        for (int c = 0; c < 20; c++) run_cycle(4'($urandom), 1'b1, 8'd0, 4'b1111, 1'b0);
        for (int c = 0; c < 12; c++) run_cycle(4'($urandom), 1'b1, 8'd0, 4'b1111, 1'b1);

        // One-cycle flush, then an enable change mid-run that must be ignored.
        run_cycle(4'b0, 1'b0, 8'd1, 4'b0001, 1'b1);
        check_val("t5_flush_vld", 32'(out_valid), 32'd0);
        check_val("t5_flush_ovf", 32'(overflow),  32'd0);
        for (int c = 0; c < 50; c++) begin
            run_cycle(4'($urandom), 1'b1, 8'd1, (c < 3) ? 4'b0001 : 4'b0010, 1'b1);
            if (out_valid) check_val("t5_chan", 32'(out_channel), 32'd0);
        end
        run_cycle(4'b0, 1'b0, 8'd1, 4'b0010, 1'b1);
        for (int c = 0; c < 40; c++) run_cycle(4'($urandom), 1'b1, 8'd1, 4'b0010, 1'b1);

        // Asynchronous reset in the middle of a word while a word is presented.
        run_cycle(4'b0, 1'b0, 8'd0, 4'b1111, 1'b0);
        for (int c = 0; c < 12; c++) run_cycle(4'($urandom), 1'b1, 8'd0, 4'b1111, 1'b0);
        check_val("t6_pre_vld", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_rst_vld",  32'(out_valid),   32'd0);
        check_val("t6_rst_data", 32'(out_data),    32'd0);
        check_val("t6_rst_chan", 32'(out_channel), 32'd0);
        check_val("t6_rst_ovf",  32'(overflow),    32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) run_cycle(4'($urandom), 1'b1, 8'd0, 4'b1111, 1'b1);

        // Randomized run: random probes, divisors, enables, backpressure and occasional flushes.
        for (int c = 0; c < 1500; c++) begin
            run_cycle(4'($urandom), $urandom_range(0, 59) != 0, 8'($urandom_range(0, 3)),
                      4'($urandom), $urandom_range(0, 3) != 0);
        end
        check_outputs();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
